squelch_fsm: RTL

Hysteresis squelch stage that sits directly downstream of the 4-bit magnitude comparator in the receive path. The comparator compares the received signal strength (A) against the squelch threshold (B). This block consumes its one-hot Less/Equal/Greater flags, one sample per `valid` strobe, and applies attack/release persistence counting. It produces a stable `carrier` gate plus single-cycle edge pulses for the downstream audio/data mute logic.

---
 rtl/squelch_fsm.sv | 132 +++++++++++++
 1 files changed

// File: rtl/squelch_fsm.sv
// Hysteresis squelch: turns one-hot comparator flags into a debounced carrier gate
// using attack/release persistence counts. It also emits single-cycle open/close pulses.
module squelch_fsm #(
  parameter int ATTACK_CNT  = 3,
  parameter int RELEASE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       less,
  input  logic       equal,
  input  logic       greater,
  output logic       carrier,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [1:0] state,
  output logic       flag_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ATTACK  = 2'b01,
    ACTIVE  = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam logic [3:0] ATK_TGT = 4'(ATTACK_CNT);
  localparam logic [3:0] REL_TGT = 4'(RELEASE_CNT);

  state_t     st;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       one_hot;
  logic       is_g;
  logic       is_l;

  // Anything that is not exactly one-hot is treated as Equal, which holds the run.
  assign one_hot = ({less, equal, greater} == 3'b001) ||
                   ({less, equal, greater} == 3'b010) ||
                   ({less, equal, greater} == 3'b100);
  assign is_g    = one_hot && greater;
  assign is_l    = one_hot && less;
  assign cnt_inc = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;
  assign state   = st;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      cnt        <= 4'd0;
      carrier    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      flag_err   <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      flag_err   <= valid && !one_hot;
      if (valid) begin
        case (st)
          IDLE: begin
            if (is_g) begin
              if (ATK_TGT == 4'd1) begin
                st         <= ACTIVE;
                cnt        <= 4'd0;
                carrier    <= 1'b1;
                rise_pulse <= 1'b1;
              end else begin
                st  <= ATTACK;
                cnt <= 4'd1;
              end
            end else begin
              cnt <= 4'd0;
            end
          end
          ATTACK: begin
            if (is_g) begin
              if (cnt_inc == ATK_TGT) begin
                st         <= ACTIVE;
                cnt        <= 4'd0;
                carrier    <= 1'b1;
                rise_pulse <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (is_l) begin
              st  <= IDLE;
              cnt <= 4'd0;
            end
          end
          ACTIVE: begin
            if (is_l) begin
              if (REL_TGT == 4'd1) begin
                st         <= IDLE;
                cnt        <= 4'd0;
                carrier    <= 1'b0;
                fall_pulse <= 1'b1;
              end else begin
                st  <= RELEASE;
                cnt <= 4'd1;
              end
            end else begin
              cnt <= 4'd0;
            end
          end
          RELEASE: begin
            if (is_l) begin
              if (cnt_inc == REL_TGT) begin
                st         <= IDLE;
                cnt        <= 4'd0;
                carrier    <= 1'b0;
                fall_pulse <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (is_g) begin
              // Bounce back to open without announcing anything downstream.
              st  <= ACTIVE;
              cnt <= 4'd0;
            end
          end
          default: begin
            st  <= IDLE;
            cnt <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
